// File: rtl/cdc_bus_handshake_pkg.sv
// Shared definitions for the graphics clock-domain-crossing blocks.
//   CDC_SYNC_STAGES_DEFAULT / _MIN / _MAX : legal synchronizer chain depths
//   src_state_t : source-side handshake state (IDLE accepts, BUSY waits for ack)
//   dst_state_t : destination-side state (EMPTY, FULL holds an unconsumed word)
//   sync_stages_legal() : range check used at elaboration
package cdc_bus_handshake_pkg;

    localparam int unsigned CDC_SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned CDC_SYNC_STAGES_MIN     = 2;
    localparam int unsigned CDC_SYNC_STAGES_MAX     = 4;

    typedef enum logic {
        SRC_IDLE = 1'b0,
        SRC_BUSY = 1'b1
    } src_state_t;

    typedef enum logic {
        DST_EMPTY = 1'b0,
        DST_FULL  = 1'b1
    } dst_state_t;

    function automatic logic sync_stages_legal(input int unsigned n);
        return (n >= CDC_SYNC_STAGES_MIN) && (n <= CDC_SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/cdc_bus_handshake_sync_bit.sv
// Single-bit synchronizer chain with synchronous, active-high reset.
//   clk   : destination clock of the chain
//   reset : synchronous reset, clears every stage to 0
//   d     : asynchronous input bit
//   q     : output of the last stage
module cdc_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_bus_handshake.sv
// Carries a WIDTH-bit word from src_clk into clk with a toggle req/ack
// handshake. The word sits in hold_q, unchanged, until the destination has
// acknowledged it, so only hold_q and the two toggle bits cross domains.
//   clk, reset          : destination clock / synchronous active-high reset
//   src_clk, src_reset  : source clock / synchronous active-high reset
//   src_valid, src_data : word offered by the producer
//   src_ready           : high when no transfer is in flight
//   dst_valid, dst_data : unconsumed word presented to the consumer
//   dst_ready           : consumer accepts the presented word
module cdc_bus_handshake
    import cdc_bus_handshake_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       SYNC_STAGES = CDC_SYNC_STAGES_DEFAULT,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src_clk,
    input  logic             src_reset,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic             dst_valid,
    output logic [WIDTH-1:0] dst_data,
    input  logic             dst_ready
);

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
        $error("cdc_bus_handshake: SYNC_STAGES must be in 2..4");
    end

    // ---------------- source domain ----------------
    src_state_t       src_state, src_state_next;
    logic             src_accept;
    logic             req_q;
    logic             ack_sync;
    logic [WIDTH-1:0] hold_q;

    always_comb begin
        src_state_next = src_state;
        src_accept     = 1'b0;
        case (src_state)
            SRC_IDLE: begin
                if (src_valid) begin
                    src_accept     = 1'b1;
                    src_state_next = SRC_BUSY;
                end
            end
            SRC_BUSY: begin
                // ack catching up with req means the word was consumed
                if (ack_sync == req_q) begin
                    src_state_next = SRC_IDLE;
                end
            end
            default: src_state_next = SRC_IDLE;
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (src_reset) begin
            src_state <= SRC_IDLE;
            req_q     <= 1'b0;
            hold_q    <= '0;
        end else begin
            src_state <= src_state_next;
            if (src_accept) begin
                hold_q <= src_data;
                req_q  <= ~req_q;
            end
        end
    end

    assign src_ready = (src_state == SRC_IDLE);

    // ---------------- destination domain ----------------
    dst_state_t dst_state, dst_state_next;
    logic       req_sync;
    logic       req_seen;
    logic       new_word;
    logic       dst_load;
    logic       dst_consume;
    logic       ack_q;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (req_q),
        .q     (req_sync)
    );

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (src_clk),
        .reset (src_reset),
        .d     (ack_q),
        .q     (ack_sync)
    );

    assign new_word = req_sync ^ req_seen;

    always_comb begin
        dst_state_next = dst_state;
        dst_load       = 1'b0;
        dst_consume    = 1'b0;
        case (dst_state)
            DST_EMPTY: begin
                // hold_q has been stable since before req toggled
                if (new_word) begin
                    dst_load       = 1'b1;
                    dst_state_next = DST_FULL;
                end
            end
            DST_FULL: begin
                if (dst_ready) begin
                    dst_consume    = 1'b1;
                    dst_state_next = DST_EMPTY;
                end
            end
            default: dst_state_next = DST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_state <= DST_EMPTY;
            dst_data  <= RESET_VALUE;
            ack_q     <= 1'b0;
            req_seen  <= 1'b0;
        end else begin
            dst_state <= dst_state_next;
            req_seen  <= req_sync;
            if (dst_load) begin
                dst_data <= hold_q;
            end
            if (dst_consume) begin
                ack_q <= ~ack_q;
            end
        end
    end

    assign dst_valid = (dst_state == DST_FULL);

endmodule
